// File: rtl/multiplier.sv
// Sequential shift-and-add unsigned multiplier.
// One multiplier bit per clock; start/ready handshake.
module multiplier #(
    parameter int WIDTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             start,
    output logic [WIDTH-1:0] product,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_product;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_sum;
    logic                 w_last;
    logic                 w_accept;

    // Next state plus the combinational add for the current iteration
    always_comb begin
        w_state_nxt = r_state;
        w_addend    = r_mplier[0] ? r_mcand : '0;
        w_acc_sum   = r_acc + w_addend;
        w_last      = (r_count == LAST);
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = BUSY;
                    w_accept    = 1'b1;
                end
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    w_state_nxt = BUSY;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Operand latch, iteration and result capture on the final step
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand   <= {{WIDTH{1'b0}}, x};
            r_mplier  <= y;
            r_acc     <= '0;
            r_count   <= '0;
        end else if (r_state == BUSY) begin
            r_acc    <= w_acc_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (w_last) r_product <= w_acc_sum[WIDTH-1:0];
        end
    end

    assign product = r_product;
    assign ready   = (r_state == DONE);

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed steps
// plus randomized operations against an arithmetic model.
module tb_multiplier;

    localparam int W = 4;

    logic         clk_in;
    logic         rst_in;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         start;
    logic [W-1:0] product;
    logic         ready;

    int checks;
    int failures;
    int exp_prod;

    multiplier #(.WIDTH(W)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .x       (x),
        .y       (y),
        .start   (start),
        .product (product),
        .ready   (ready)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic int model(int a, int b);
        return (a * b) % (1 << W);
    endfunction

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One operation: start sampled at E0, ready expected after E0+W.
    // Inputs are scrambled during BUSY; optionally start is pulsed too.
    task automatic run_op(int a, int b, bit poke);
        int prev;
        prev = exp_prod;
        x = W'(a);
        y = W'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < W; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            start = poke && (i == 1);
            tick();
            check("busy_ready", int'(ready), 0);
            check("busy_prod", int'(product), prev);
        end
        start = 1'b0;
        tick();
        exp_prod = model(a, b);
        check("done_ready", int'(ready), 1);
        check("done_prod", int'(product), exp_prod);
        tick();
        check("idle_ready", int'(ready), 0);
        check("idle_prod", int'(product), exp_prod);
    endtask

    initial begin
        int gap;
        checks   = 0;
        failures = 0;
        exp_prod = 0;
        x = '0;
        y = '0;
        start  = 1'b0;
        rst_in = 1'b0;

        #2;
        check("rst_prod", int'(product), 0);
        check("rst_ready", int'(ready), 0);
        tick();
        check("rst_hold_ready", int'(ready), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick();
        tick();
        check("post_rst_prod", int'(product), 0);
        check("post_rst_ready", int'(ready), 0);

        run_op(11, 1, 1'b0);
        run_op(11, 11, 1'b0);
        run_op(3, 5, 1'b0);
        run_op(15, 15, 1'b0);
        run_op(0, 13, 1'b1);
        run_op(7, 9, 1'b1);

        for (int n = 0; n < 20; n++) begin
            run_op(int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)),
                   1'($urandom));
        end

        // Back-to-back with start held high
        x = 4'd2;
        y = 4'd3;
        start = 1'b1;
        tick();
        for (int i = 0; i < 10 && !ready; i++) tick();
        check("b2b_first_ready", int'(ready), 1);
        check("b2b_first_prod", int'(product), 6);
        x = 4'd4;
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            gap++;
            if (ready) break;
        end
        check("b2b_gap", gap, W + 1);
        check("b2b_second_prod", int'(product), 12);
        start = 1'b0;
        tick();
        check("b2b_idle_ready", int'(ready), 0);
        check("b2b_idle_prod", int'(product), 12);

        // Async reset two edges into a 7*7 operation
        x = 4'd7;
        y = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_prod", int'(product), 0);
        check("async_rst_ready", int'(ready), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready || product != 0) gap++;
        end
        check("abort_no_done", gap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
